// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one alu1 slice evaluates a WIDTH-bit ADD/SUB/logic op LSB first,
// one bit per clock, with a start/done handshake and carryout/overflow/zero flags.

module alu1 (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] control_i,
  output logic       out_o,
  output logic       cout_o
);
  logic b_eff;
  logic sum;

  // control[0] inverts B so that SUB becomes A + ~B + 1 with cin=1
  assign b_eff  = b_i ^ control_i[0];
  assign sum    = a_i ^ b_eff ^ cin_i;
  assign cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));

  always_comb begin
    out_o = sum;
    if (control_i[2]) begin
      case (control_i[1:0])
        2'b00:   out_o = a_i & b_i;
        2'b01:   out_o = a_i | b_i;
        2'b10:   out_o = ~(a_i | b_i);
        default: out_o = a_i ^ b_i;
      endcase
    end
  end
endmodule

module serial_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [2:0]         ctrl_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   out_q;
  logic               busy_q;
  logic               done_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;
  logic               slice_out;
  logic               slice_cout;

  alu1 u_slice (
    .a_i       (a_sh_q[0]),
    .b_i       (b_sh_q[0]),
    .cin_i     (carry_q),
    .control_i (ctrl_q),
    .out_o     (slice_out),
    .cout_o    (slice_cout)
  );

  // Shadow result with the current slice bit merged in; becomes visible only on entry to FIN
  always_comb begin
    res_d        = res_q;
    res_d[cnt_q] = slice_out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      ctrl_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            ctrl_q  <= control;
            carry_q <= control[0];
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= slice_cout;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // carry_q here is still the carry into the MSB slice
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= res_d;
            cout_q  <= ~ctrl_q[2] & slice_cout;
            ovf_q   <= ~ctrl_q[2] & (slice_cout ^ carry_q);
            zero_q  <= (res_d == '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: vector table on a 32-bit instance plus
// handshake, mid-op reset and a 4-bit instance sequence.

module tb_serial_alu_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  control = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, carryout, overflow, zero;
  logic [31:0] out;

  logic        start4 = 1'b0;
  logic [2:0]  ctl4 = '0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        busy4, done4, c4, v4, z4;
  logic [3:0]  out4;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  serial_alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .control(control), .A(A), .B(B),
    .busy(busy), .done(done), .out(out), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  serial_alu_seq #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .control(ctl4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .out(out4), .carryout(c4), .overflow(v4), .zero(z4)
  );

  typedef struct {
    string       name;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns cycles from accept edge until done is seen
  task automatic run32(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    control = ctl;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  seen;

    vecs[0]  = '{"add_wrap",  3'd2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{"sub_neg",   3'd3, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"add_ovf",   3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"nor_zero",  3'd6, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"xor_same",  3'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"and_mix",   3'd4, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"or_mix",    3'd5, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"sub_eq",    3'd3, 32'h0000_000A, 32'h0000_000A, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{"ctl0_add",  3'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"ctl1_sub",  3'd1, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"sub_ovf",   3'd3, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{"and_ones",  3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", out, 32'h0);
    chk("rst_flags", {carryout, overflow, zero}, 3'b000);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) begin
      run32(vecs[i].ctl, vecs[i].a, vecs[i].b, lat, bok);
      chk({vecs[i].name, "_lat"}, lat, 32);
      chk({vecs[i].name, "_busy"}, bok, 1'b1);
      chk({vecs[i].name, "_out"}, out, vecs[i].res);
      chk({vecs[i].name, "_c"}, carryout, vecs[i].c);
      chk({vecs[i].name, "_v"}, overflow, vecs[i].v);
      chk({vecs[i].name, "_z"}, zero, vecs[i].z);
      chk({vecs[i].name, "_fin_busy"}, busy, 1'b0);
      @(posedge clock); #1;
      chk({vecs[i].name, "_pulse"}, done, 1'b0);
      chk({vecs[i].name, "_hold"}, out, vecs[i].res);
    end

    // Idle holds outputs
    repeat (3) @(posedge clock);
    #1;
    chk("idle_hold_out", out, 32'hFFFF_FFFF);
    chk("idle_done", done, 1'b0);

    // start held high through RUN, then back-to-back accept in FIN
    control = 3'd2; A = 32'd3; B = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    control = 3'd3; A = 32'd100; B = 32'd1;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("hold_lat", lat, 32);
    chk("hold_out", out, 32'd7);
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done", done, 1'b0);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("b2b_lat", lat, 32);
    chk("b2b_out", out, 32'd99);
    chk("b2b_c", carryout, 1'b1);
    @(posedge clock); #1;
    chk("b2b_pulse", done, 1'b0);
    chk("b2b_idle_busy", busy, 1'b0);

    // Asynchronous reset in the middle of an op
    control = 3'd2; A = 32'h1234_5678; B = 32'h1111_1111; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_out", out, 32'h0);
    chk("mid_rst_flags", {carryout, overflow, zero}, 3'b000);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 1'b0);
    run32(3'd2, 32'd3, 32'd4, lat, bok);
    chk("after_rst_lat", lat, 32);
    chk("after_rst_out", out, 32'd7);
    @(posedge clock); #1;

    // 4-bit instance
    ctl4 = 3'd3; a4 = 4'h8; b4 = 4'h1; start4 = 1'b1;
    @(posedge clock); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("w4_sub_lat", lat, 4);
    chk("w4_sub_out", {28'h0, out4}, 32'h7);
    chk("w4_sub_flags", {c4, v4, z4}, 3'b110);
    @(posedge clock); #1;
    ctl4 = 3'd2; a4 = 4'h7; b4 = 4'h1; start4 = 1'b1;
    @(posedge clock); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("w4_add_lat", lat, 4);
    chk("w4_add_out", {28'h0, out4}, 32'h8);
    chk("w4_add_flags", {c4, v4, z4}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
